// File: rtl/score_inc_if.sv
// Award bus between point requesters and the score increment scheduler.
// One request/points pair per source; the scheduler answers with a one-hot ack.
interface score_inc_if #(
  parameter int NUM_SRC = 2,
  parameter int PTS_W   = 3
);
  logic [NUM_SRC-1:0]       req;
  logic [NUM_SRC*PTS_W-1:0] req_pts;
  logic [NUM_SRC-1:0]       ack;

  modport master (output req, output req_pts, input ack);
  modport slave  (input req, input req_pts, output ack);
endinterface

// File: rtl/score_inc_scheduler.sv
// Round-robin award arbiter feeding a pending-point counter that is drained as
// spaced single-cycle score_inc pulses, with a 0..99 shadow score that saturates.
module score_inc_scheduler #(
  parameter int NUM_SRC = 2,
  parameter int PTS_W   = 3,
  parameter int PEND_W  = 7,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              game_reset_i,
  score_inc_if.slave        award_if,
  output logic              score_inc_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              saturated_o
);
  localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PEND_W-1:0] PMAX      = {PEND_W{1'b1}};
  localparam logic [6:0]        SCORE_MAX = 7'd99;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [6:0]        shadow_q, shadow_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sat_q, sat_d;

  logic              found_raw_s;
  logic              found_s;
  logic [RR_W-1:0]   win_s;
  logic [PTS_W-1:0]  win_pts_s;
  logic [PEND_W-1:0] free_s;
  logic [PEND_W-1:0] acc_s;
  logic              pulse_s;
  logic              sat_hit_s;

  // Round-robin search from rr_q; a source is eligible if its award fits, or always once saturated
  always_comb begin
    int               idx;
    logic [PTS_W-1:0] pts_v;
    found_raw_s = 1'b0;
    win_s       = '0;
    win_pts_s   = '0;
    idx         = 0;
    pts_v       = '0;
    free_s      = PMAX - pending_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx   = (int'(rr_q) + k) % NUM_SRC;
      pts_v = award_if.req_pts[idx*PTS_W +: PTS_W];
      if (!found_raw_s && award_if.req[idx] && (sat_q || (PEND_W'(pts_v) <= free_s))) begin
        found_raw_s = 1'b1;
        win_s       = RR_W'(idx);
        win_pts_s   = pts_v;
      end else begin
        found_raw_s = found_raw_s;
      end
    end
  end

  // No grant may be issued while in reset or while a new game is being started
  assign found_s   = found_raw_s && resetn && !game_reset_i;
  assign pulse_s   = (state_q == ST_PULSE);
  assign sat_hit_s = pulse_s && (shadow_q == (SCORE_MAX - 7'd1));
  assign acc_s     = (found_s && !sat_q) ? PEND_W'(win_pts_s) : '0;

  // Next-state logic of the pulse FSM
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (game_reset_i) begin
      state_d = ST_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((pending_q != '0) && !sat_q) begin
            state_d = ST_PULSE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PULSE: begin
          if (sat_hit_s) begin
            state_d = ST_IDLE;
          end else if (GAP == 0) begin
            // pending_q still includes this pulse, so more than one point must remain
            state_d = (pending_q > PEND_W'(1)) ? ST_PULSE : ST_IDLE;
          end else begin
            state_d = ST_WAIT;
            gap_d   = GAP_W'(GAP - 1);
          end
        end
        ST_WAIT: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
          end else if ((pending_q != '0) && !sat_q) begin
            state_d = ST_PULSE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end
      endcase
    end
  end

  // Pending count, shadow score, saturation flag and round-robin pointer updates
  always_comb begin
    shadow_d  = shadow_q + {6'd0, pulse_s};
    sat_d     = (shadow_d == SCORE_MAX);
    pending_d = pending_q + acc_s - {{(PEND_W-1){1'b0}}, pulse_s};
    if (found_s) begin
      rr_d = (win_s == RR_W'(NUM_SRC - 1)) ? '0 : (win_s + RR_W'(1));
    end else begin
      rr_d = rr_q;
    end
    if (sat_hit_s) begin
      pending_d = '0;
    end else begin
      pending_d = pending_d;
    end
    if (game_reset_i) begin
      shadow_d  = '0;
      sat_d     = 1'b0;
      pending_d = '0;
      rr_d      = '0;
    end else begin
      shadow_d  = shadow_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      shadow_q  <= '0;
      rr_q      <= '0;
      gap_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      sat_q     <= sat_d;
    end
  end

  // Output decode from registered state
  always_comb begin
    score_inc_o = (state_q == ST_PULSE);
    busy_o      = (pending_q != '0) || (state_q != ST_IDLE);
    pending_o   = pending_q;
    saturated_o = sat_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      award_if.ack[i] = found_s && (win_s == RR_W'(i));
    end
  end
endmodule

// File: tb/tb_score_inc_scheduler.sv
// Scoreboard bench: two schedulers (GAP=2 and GAP=0) share one stimulus stream and
// are compared against a rule-level model of arbitration, pending and pulse spacing.
module tb_score_inc_scheduler;
  localparam int NS   = 2;
  localparam int PW   = 3;
  localparam int EW   = 7;
  localparam int PMAX = 127;

  typedef struct {int cyc; int v;} ev_t;
  typedef struct {int cyc; int pend; int sat; int busy;} st_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic game_reset = 1'b0;
  logic [NS-1:0]    req_v = '0;
  logic [NS*PW-1:0] pts_v = '0;
  logic             sc [2];
  logic             bz [2];
  logic             st [2];
  logic [EW-1:0]    pn [2];

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  ev_t ack_q [2][$];
  ev_t pls_q [2][$];
  st_t st_q  [2][$];

  int  m_pend [2];
  int  m_shadow [2];
  int  m_sat [2];
  int  m_rr [2];
  int  m_pulse [2];
  int  m_last [2];
  int  m_wait_end [2];

  always #5 clk = ~clk;

  score_inc_if #(.NUM_SRC(NS), .PTS_W(PW)) if0 ();
  score_inc_if #(.NUM_SRC(NS), .PTS_W(PW)) if1 ();
  assign if0.req     = req_v;
  assign if0.req_pts = pts_v;
  assign if1.req     = req_v;
  assign if1.req_pts = pts_v;

  score_inc_scheduler #(.NUM_SRC(NS), .PTS_W(PW), .PEND_W(EW), .GAP(2)) u_gap2 (
    .clk(clk), .resetn(resetn), .game_reset_i(game_reset), .award_if(if0),
    .score_inc_o(sc[0]), .busy_o(bz[0]), .pending_o(pn[0]), .saturated_o(st[0]));

  score_inc_scheduler #(.NUM_SRC(NS), .PTS_W(PW), .PEND_W(EW), .GAP(0)) u_gap0 (
    .clk(clk), .resetn(resetn), .game_reset_i(game_reset), .award_if(if1),
    .score_inc_o(sc[1]), .busy_o(bz[1]), .pending_o(pn[1]), .saturated_o(st[1]));

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_clear(input int i);
    m_pend[i] = 0; m_shadow[i] = 0; m_sat[i] = 0; m_rr[i] = 0;
    m_pulse[i] = 0; m_last[i] = -1000; m_wait_end[i] = -1;
  endtask

  // Reference: expectations for this cycle, then advance to the next cycle
  task automatic model_cycle(input int i, input logic [NS-1:0] rq,
                             input logic [NS*PW-1:0] pt, input logic gr);
    int w, s, p, acc, sh_n, nxt, busy;
    bit hit;
    w = -1;
    if (!gr) begin
      for (int k = 0; k < NS; k++) begin
        s = (m_rr[i] + k) % NS;
        p = int'(pt[s*PW +: PW]);
        if (w < 0 && rq[s] && (m_sat[i] != 0 || p <= PMAX - m_pend[i])) w = s;
      end
    end
    if (w >= 0) ack_q[i].push_back('{cyc, w});
    if (m_pulse[i] != 0) pls_q[i].push_back('{cyc, m_shadow[i] + 1});
    busy = (m_pend[i] != 0 || m_pulse[i] != 0 || cyc <= m_wait_end[i]) ? 1 : 0;
    st_q[i].push_back('{cyc, m_pend[i], m_sat[i], busy});
    if (gr) begin
      model_clear(i);
    end else begin
      acc  = (w >= 0 && m_sat[i] == 0) ? int'(pt[w*PW +: PW]) : 0;
      sh_n = m_shadow[i] + m_pulse[i];
      hit  = (m_pulse[i] != 0) && (sh_n == 99);
      if (m_pulse[i] != 0) begin
        m_last[i] = cyc;
        if (!hit) m_wait_end[i] = cyc + gap_of(i);
      end
      // Next pulse: spacing honoured, points left after this cycle's pulse, not saturated
      nxt = (m_sat[i] == 0 && !hit && (cyc - m_last[i] >= gap_of(i)) &&
             (m_pend[i] - m_pulse[i] > 0)) ? 1 : 0;
      m_pend[i]   = hit ? 0 : (m_pend[i] + acc - m_pulse[i]);
      m_shadow[i] = sh_n;
      m_sat[i]    = (sh_n == 99) ? 1 : 0;
      if (w >= 0) m_rr[i] = (w + 1) % NS;
      m_pulse[i]  = nxt;
    end
  endtask

  task automatic step(input logic [NS-1:0] rq, input logic [NS*PW-1:0] pt, input logic gr);
    req_v = rq;
    pts_v = pt;
    game_reset = gr;
    model_cycle(0, rq, pt, gr);
    model_cycle(1, rq, pt, gr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step('0, '0, 1'b0);
  endtask

  // Monitor: compare DUT outputs with queued expectations, away from the clock edge
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [NS-1:0] a;
        int  ai, ea, ep;
        ev_t e;
        st_t t;
        a  = (i == 0) ? if0.ack : if1.ack;
        ai = -1;
        for (int j = NS - 1; j >= 0; j--) if (a[j]) ai = j;
        if (a != '0) chk("ack_onehot", i, $countones(a), 1);
        ea = -1;
        if (ack_q[i].size() > 0 && ack_q[i][0].cyc == cyc) begin
          e = ack_q[i].pop_front();
          ea = e.v;
        end
        if (ea >= 0 || ai >= 0) chk("ack_src", i, ai, ea);
        ep = -1;
        if (pls_q[i].size() > 0 && pls_q[i][0].cyc == cyc) begin
          e = pls_q[i].pop_front();
          ep = e.cyc;
        end
        if (ep >= 0 || sc[i]) chk("score_inc_cyc", i, sc[i] ? cyc : -1, ep);
        if (st_q[i].size() > 0 && st_q[i][0].cyc == cyc) begin
          t = st_q[i].pop_front();
          chk("pending", i, int'(pn[i]), t.pend);
          chk("saturated", i, int'(st[i]), t.sat);
          chk("busy", i, int'(bz[i]), t.busy);
        end else begin
          chk("status_entry", i, 0, 1);
        end
      end
    end
  end

  initial begin
    model_clear(0);
    model_clear(1);
    resetn = 1'b0;
    req_v  = 2'b11;
    pts_v  = 6'o25;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", i, int'((i == 0) ? if0.ack : if1.ack), 0);
      chk("rst_score_inc", i, int'(sc[i]), 0);
      chk("rst_pending", i, int'(pn[i]), 0);
      chk("rst_busy", i, int'(bz[i]), 0);
      chk("rst_saturated", i, int'(st[i]), 0);
    end
    resetn = 1'b1;
    req_v  = '0;
    pts_v  = '0;
    mon_en = 1'b1;

    // Single 3-point award from idle
    step(2'b01, 6'o03, 1'b0);
    idle(12);
    // Two sources with 1 point each held: grants must alternate
    for (int j = 0; j < 10; j++) step(2'b11, 6'o11, 1'b0);
    idle(2);
    // Fill towards PMAX, then a 4-point request waits until room appears
    step('0, '0, 1'b1);
    for (int j = 0; j < 50; j++) step(2'b11, 6'o77, 1'b0);
    for (int j = 0; j < 30; j++) step(2'b01, 6'o04, 1'b0);
    step('0, '0, 1'b1);
    // Bring shadow to 97, then a 5-point award saturates after two pulses
    for (int j = 0; j < 13; j++) step(2'b01, 6'o07, 1'b0);
    step(2'b01, 6'o06, 1'b0);
    idle(310);
    step(2'b10, 6'o50, 1'b0);
    idle(12);
    for (int j = 0; j < 8; j++) step(2'b11, 6'o35, 1'b0);
    idle(4);
    // New game started while waiting between pulses with points still pending
    step('0, '0, 1'b1);
    step(2'b01, 6'o06, 1'b0);
    idle(2);
    step('0, '0, 1'b1);
    idle(6);
    // Back-to-back burst plus an award landing on a pulse cycle
    step(2'b01, 6'o04, 1'b0);
    idle(3);
    step(2'b01, 6'o02, 1'b0);
    idle(12);
    // Randomised traffic with occasional new-game clears
    for (int j = 0; j < 400; j++) begin
      step(NS'($urandom), (NS*PW)'($urandom), ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end
    idle(20);
    mon_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("ack_q_drained", i, ack_q[i].size(), 0);
      chk("pulse_q_drained", i, pls_q[i].size(), 0);
      chk("status_q_drained", i, st_q[i].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
